reg_serial_tx: RTL
==================

REG_SERIAL_TX -- requirements
Module: reg_serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning payload bits per frame (legal range 1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles each serial bit is held (legal range 1..256).
REQ-003 SHALL have port clk, input, 1, meaning the system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port load_valid, input, 1, meaning that load_data is offered for transmission.
REQ-006 SHALL have port load_data, input, WIDTH, meaning the parallel word to serialize.
REQ-007 SHALL have port load_ready, output, 1, meaning the block can accept a word this cycle.
REQ-008 SHALL have port tx_out, output, 1, meaning the registered serial line output; idles at 1.
REQ-009 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle pulse on frame completion.

Function
REQ-011 SHALL accept a word on the rising edge where load_valid=1 and load_ready=1, capturing load_data into an internal shift register on that edge.
REQ-012 SHALL ignore load_valid and load_data while load_ready=0, with no queueing of offered words.
REQ-013 SHALL transmit each frame as a start bit (0), then WIDTH data bits LSB first, then a stop bit (1).
REQ-014 SHALL hold every frame bit on tx_out for exactly CLKS_PER_BIT cycles.
REQ-015 SHALL make each frame occupy exactly (WIDTH+2)*CLKS_PER_BIT cycles, with the start bit appearing the cycle after acceptance.
REQ-016 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-017 SHALL use these FSM transitions: IDLE->START on accept; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after WIDTH bit periods; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-018 SHALL track the data bit index with a counter of width $clog2(WIDTH+1), and the in-bit cycle count with a counter of width $clog2(CLKS_PER_BIT+1); both counters SHALL clear on every bit boundary and on entry to START.
REQ-019 SHALL drive load_ready=1 only in IDLE, combinationally from state.
REQ-020 SHALL drive busy=1 in START, DATA and STOP.
REQ-021 SHALL pulse done=1 for exactly one cycle, the first IDLE cycle after the STOP bit period; load_ready SHALL also be 1 in that cycle.
REQ-022 SHALL support back-to-back frames: a word accepted in the done cycle SHALL have its start bit in the next cycle, with no extra idle bit.
REQ-023 SHALL produce no glitch on tx_out, because tx_out is a flop output.
REQ-024 SHALL leave the in-flight frame uncorrupted when load_data changes mid-frame.

Reset
REQ-025 SHALL, while reset=1 and independent of clk, force state=IDLE, tx_out=1, busy=0, done=0, load_ready=1, and clear the shift register and all counters.
REQ-026 SHALL, on reset assertion mid-frame, abort the frame immediately, return tx_out to 1, and never emit a done pulse for the aborted frame.
REQ-027 SHALL make the first accept possible on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL take the FSM state typedef (IDLE/START/DATA/STOP) and the START_BIT=0 and STOP_BIT=1 constants from shared package reg_serial_pkg.
REQ-029 SHALL contain exactly one sub-module, bit_timer, parameterized by CLKS_PER_BIT, providing the cycle counter and a bit_end strobe.

Verification
REQ-030 SHALL cover this scenario (WIDTH=4, CLKS_PER_BIT=4): load 4'b1011 -> tx_out is 0,1,1,0,1,1, each value held 4 cycles (24 cycles total), then done is high for 1 cycle and load_ready is 1.
REQ-031 SHALL cover this scenario: hold load_valid=1 with 4'hA and then 4'h5 on consecutive frames -> two 24-cycle frames with no idle gap between them, the second word accepted in the done cycle, and exactly two done pulses.
REQ-032 SHALL cover this scenario: pulse load_valid with 4'hF while busy -> the word is ignored, the frame in flight is unchanged, and no extra frame is sent.
REQ-033 SHALL cover this scenario: assert reset for 3 time units at cycle 10 of a frame -> tx_out=1, busy=0 and load_ready=1 immediately, with no done pulse.
REQ-034 SHALL cover this scenario (CLKS_PER_BIT=1): load 4'h0 -> tx_out is 0,0,0,0,0,1 over 6 cycles, then done.
REQ-035 SHALL cover this scenario: idle for 50 cycles with load_valid=0 -> tx_out stays constant at 1 and done stays 0.

Source files
------------

// File: rtl/reg_serial_pkg.sv
// Shared FSM state encoding and line-level constants for the serial transmitter.
package reg_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Counts clk cycles within one serial bit and strobes bit_end on the last cycle.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == CW'(CLKS_PER_BIT - 1));

    // Counter restarts at every bit boundary and whenever a new frame begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || bit_end) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reg_serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
module reg_serial_tx
    import reg_serial_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic             bit_end;
    logic             accept;

    assign load_ready = (state == IDLE);
    assign accept     = load_valid && load_ready;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (state != IDLE),
        .clr     (accept),
        .bit_end (bit_end)
    );

    // Each transition loads tx_out with the next bit so the line changes exactly on bit boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx_out  <= STOP_BIT;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= START;
                        busy    <= 1'b1;
                        tx_out  <= START_BIT;
                        shreg   <= load_data;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IW'(WIDTH - 1)) begin
                            state   <= STOP;
                            tx_out  <= STOP_BIT;
                            bit_idx <= '0;
                        end else begin
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
